// File: rtl/swi_debounce_sync.sv
// Two-flop synchroniser plus whole-word debouncer for the SWI switch bank.
// Produces a committed switch word, a one-cycle change strobe and per-bit rise pulses.
module swi_debounce_sync #(
  parameter  int NBITS           = 8,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] sw_in,
  output logic [NBITS-1:0] sw_stable,
  output logic             sw_changed,
  output logic [NBITS-1:0] sw_rise,
  output logic             settling
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [NBITS-1:0]   sync1_q, sync2_q;
  logic [NBITS-1:0]   cand_q, cand_d;
  logic [NBITS-1:0]   stable_q, stable_d;
  logic [NBITS-1:0]   rise_q, rise_d;
  logic               changed_q, changed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // The FSM only ever looks at sync2_q, the second synchroniser stage.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    rise_d    = '0;
    case (state_q)
      IDLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_q == stable_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = cand_q;
          changed_d = 1'b1;
          rise_d    = cand_q & ~stable_q;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sw_in;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_changed = changed_q;
  assign sw_rise    = rise_q;
  assign settling   = (state_q == SETTLE);

endmodule

// File: tb/tb_swi_debounce_sync.sv
// Directed bench for swi_debounce_sync: per-cycle vector table on the default
// configuration plus a short hand sequence on a DEBOUNCE_CYCLES=2, NBITS=4 instance.
module tb_swi_debounce_sync;

  logic       clk_2 = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] sw_a;
  logic [3:0] sw_b;
  logic [7:0] stb_a, rise_a;
  logic [3:0] stb_b, rise_b;
  logic       chg_a, stl_a, chg_b, stl_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_2 = ~clk_2;

  swi_debounce_sync #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk_2(clk_2), .reset(rst_a), .sw_in(sw_a),
    .sw_stable(stb_a), .sw_changed(chg_a), .sw_rise(rise_a), .settling(stl_a)
  );

  swi_debounce_sync #(.NBITS(4), .DEBOUNCE_CYCLES(2)) dut_b (
    .clk_2(clk_2), .reset(rst_b), .sw_in(sw_b),
    .sw_stable(stb_b), .sw_changed(chg_b), .sw_rise(rise_b), .settling(stl_b)
  );

  typedef struct {
    logic       rst;
    logic [7:0] sw;
    logic [7:0] stb;
    logic       chg;
    logic [7:0] rise;
    logic       stl;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  task automatic add(input logic r, input logic [7:0] s, input logic [7:0] st,
                     input logic c, input logic [7:0] ri, input logic sl);
    tv[nv] = '{rst: r, sw: s, stb: st, chg: c, rise: ri, stl: sl};
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    rst_a = 1'b1; sw_a = 8'h00;
    rst_b = 1'b1; sw_b = 4'h0;

    // reset, sw_in = 0
    add(1, 8'h00, 8'h00, 0, 8'h00, 0);
    add(1, 8'h00, 8'h00, 0, 8'h00, 0);
    // bounce: 04 for two cycles then back to 00
    add(0, 8'h04, 8'h00, 0, 8'h00, 0);
    add(0, 8'h04, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 0);
    // clean step to 0C, commit on edge k+5
    add(0, 8'h0C, 8'h00, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h0C, 1, 8'h0C, 0);
    add(0, 8'h0C, 8'h0C, 0, 8'h00, 0);
    // reset back to zero, then candidate restart 01 -> 03
    add(1, 8'h00, 8'h00, 0, 8'h00, 0);
    add(1, 8'h00, 8'h00, 0, 8'h00, 0);
    add(0, 8'h01, 8'h00, 0, 8'h00, 0);
    add(0, 8'h01, 8'h00, 0, 8'h00, 0);
    add(0, 8'h03, 8'h00, 0, 8'h00, 1);
    add(0, 8'h03, 8'h00, 0, 8'h00, 1);
    add(0, 8'h03, 8'h00, 0, 8'h00, 1);
    add(0, 8'h03, 8'h00, 0, 8'h00, 1);
    add(0, 8'h03, 8'h00, 0, 8'h00, 1);
    add(0, 8'h03, 8'h03, 1, 8'h03, 0);
    add(0, 8'h03, 8'h03, 0, 8'h00, 0);
    // step to FF (rise only on the new bits)
    add(0, 8'hFF, 8'h03, 0, 8'h00, 0);
    add(0, 8'hFF, 8'h03, 0, 8'h00, 0);
    add(0, 8'hFF, 8'h03, 0, 8'h00, 1);
    add(0, 8'hFF, 8'h03, 0, 8'h00, 1);
    add(0, 8'hFF, 8'h03, 0, 8'h00, 1);
    add(0, 8'hFF, 8'hFF, 1, 8'hFC, 0);
    // falling edge FF -> 0F: change strobe, no rise
    add(0, 8'h0F, 8'hFF, 0, 8'h00, 0);
    add(0, 8'h0F, 8'hFF, 0, 8'h00, 0);
    add(0, 8'h0F, 8'hFF, 0, 8'h00, 1);
    add(0, 8'h0F, 8'hFF, 0, 8'h00, 1);
    add(0, 8'h0F, 8'hFF, 0, 8'h00, 1);
    add(0, 8'h0F, 8'h0F, 1, 8'h00, 0);
    add(0, 8'h0F, 8'h0F, 0, 8'h00, 0);
    // step to 0C interrupted by reset at k+3, then release with 0C held
    add(0, 8'h0C, 8'h0F, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h0F, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h0F, 0, 8'h00, 1);
    add(1, 8'h0C, 8'h00, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 0);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h00, 0, 8'h00, 1);
    add(0, 8'h0C, 8'h0C, 1, 8'h0C, 0);
    add(0, 8'h0C, 8'h0C, 0, 8'h00, 0);

    for (int i = 0; i < nv; i++) begin
      rst_a = tv[i].rst;
      sw_a  = tv[i].sw;
      @(posedge clk_2);
      #1;
      chk("sw_stable",  i, stb_a,        tv[i].stb);
      chk("sw_changed", i, {7'd0, chg_a}, {7'd0, tv[i].chg});
      chk("sw_rise",    i, rise_a,       tv[i].rise);
      chk("settling",   i, {7'd0, stl_a}, {7'd0, tv[i].stl});
    end

    // DEBOUNCE_CYCLES=2 instance: reset, then step 4'h5 commits at edge k+3
    rst_b = 1'b1; sw_b = 4'h0;
    @(posedge clk_2); #1;
    @(posedge clk_2); #1;
    chk("b_reset_stable", 0, {4'd0, stb_b}, 8'h00);
    chk("b_reset_settle", 0, {7'd0, stl_b}, 8'h00);
    rst_b = 1'b0; sw_b = 4'h5;
    @(posedge clk_2); #1;
    chk("b_k_settle",     1, {7'd0, stl_b}, 8'h00);
    @(posedge clk_2); #1;
    chk("b_k1_settle",    2, {7'd0, stl_b}, 8'h00);
    @(posedge clk_2); #1;
    chk("b_k2_settle",    3, {7'd0, stl_b}, 8'h01);
    chk("b_k2_stable",    3, {4'd0, stb_b}, 8'h00);
    @(posedge clk_2); #1;
    chk("b_k3_stable",    4, {4'd0, stb_b}, 8'h05);
    chk("b_k3_changed",   4, {7'd0, chg_b}, 8'h01);
    chk("b_k3_rise",      4, {4'd0, rise_b}, 8'h05);
    chk("b_k3_settle",    4, {7'd0, stl_b}, 8'h00);
    @(posedge clk_2); #1;
    chk("b_k4_changed",   5, {7'd0, chg_b}, 8'h00);
    chk("b_k4_rise",      5, {4'd0, rise_b}, 8'h00);
    chk("b_k4_stable",    5, {4'd0, stb_b}, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
